// File: rtl/rad_conv_arbiter.sv
// Two-requester round-robin degree-to-radian converter: restoring divide by 180,
// then one multiply by pi (2.14), returning a 2.30 two's-complement result.
module rad_conv_arbiter (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req,
  input  logic signed [31:0] deg0,
  input  logic signed [31:0] deg1,
  output logic [1:0]         grant,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_id,
  output logic [31:0]        rad,
  output logic               err
);

  localparam int          DATA_W  = 32;
  localparam logic [15:0] PI_Q14  = 16'hC90F;
  localparam logic [8:0]  DIVISOR = 9'd180;
  localparam logic [31:0] MAX_DEG = 32'd90;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_MULT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                rr_q, rr_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [8:0]          rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic                sign_q, sign_d;
  logic                id_q, id_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rad_q, rad_d;

  logic                win_id;
  logic signed [31:0]  deg_sel;
  logic [31:0]         mag;
  logic [8:0]          rem_shift;
  logic                rem_ge;
  logic [47:0]         prod;
  logic [1:0]          grant_c;
  logic                unused_bits;

  function automatic logic [8:0] f_clamp(input logic [31:0] m);
    return (m > MAX_DEG) ? MAX_DEG[8:0] : m[8:0];
  endfunction

  function automatic logic [31:0] f_apply_sign(input logic [31:0] m, input logic neg);
    return neg ? (~m + 32'd1) : m;
  endfunction

  // rr_q == 0 favours requester 0; a lone request always wins.
  assign win_id    = (req[0] && (!req[1] || !rr_q)) ? 1'b0 : 1'b1;
  assign deg_sel   = win_id ? deg1 : deg0;
  assign mag       = deg_sel[31] ? (~deg_sel + 32'd1) : deg_sel;
  assign rem_shift = {rem_q[7:0], 1'b0};
  assign rem_ge    = (rem_shift >= DIVISOR);
  assign prod      = {16'd0, quo_q} * {32'd0, PI_Q14};

  // The remainder never exceeds 179, so its top bit and the product's low bits are dropped.
  assign unused_bits = ^{prod[15:0], rem_q[8]};

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    sign_d  = sign_q;
    id_d    = id_q;
    err_d   = err_q;
    rad_d   = rad_q;
    grant_c = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_c = win_id ? 2'b10 : 2'b01;
          rr_d    = ~win_id;
          id_d    = win_id;
          sign_d  = deg_sel[31];
          err_d   = (mag > MAX_DEG);
          rem_d   = f_clamp(mag);
          quo_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        rem_d = rem_ge ? (rem_shift - DIVISOR) : rem_shift;
        quo_d = {quo_q[DATA_W-2:0], rem_ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_MULT;
      end
      S_MULT: begin
        rad_d   = f_apply_sign(prod[47:16], sign_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      sign_q  <= 1'b0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      rad_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      sign_q  <= sign_d;
      id_q    <= id_d;
      err_q   <= err_d;
      rad_q   <= rad_d;
    end
  end

  // Grant is combinational in IDLE, so it is masked while reset is held.
  assign grant     = grant_c & {2{reset}};
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_id    = id_q;
  assign rad       = rad_q;
  assign err       = err_q;

endmodule

// File: doc/rad_conv_arbiter.md
# rad_conv_arbiter

Shared, sequenced degree-to-radian conversion unit for the pong physics path. It arbitrates round-robin between two requesters, for example ball-bounce and paddle-deflection logic, both of which need an angle converted. For the granted request it runs a multi-cycle restoring divide-by-180 followed by a single multiply by pi. It returns a 2.30 two's-complement radian result under a valid/ready handshake.

## Interface
- No parameters; fixed two requesters, 32-bit datapath.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in 2: per-requester request; bit i is held high with `deg_i` stable until `grant[i]` pulses.
- `deg0` in 32: requester 0 angle, signed integer degrees.
- `deg1` in 32: requester 1 angle, signed integer degrees.
- `grant` out 2: one-hot, one-cycle pulse when a request is accepted and its angle latched.
- `busy` out 1: high in every state except IDLE.
- `out_valid` out 1: result valid; held until consumed.
- `out_ready` in 1: consumer accepts the result when `out_valid & out_ready`.
- `out_id` out 1: index of the requester that owns `rad`.
- `rad` out 32: radians, 2 integer + 30 fraction bits, two's complement.
- `err` out 1: the input was outside [-90, 90] and was clamped; qualified by `out_valid`.

## Operation
- States: IDLE, DIV, MULT, DONE.
- IDLE, with any `req` bit high:
  - Pick the winner by round-robin. The priority pointer favours requester 0 after reset; after serving requester i, the other requester has priority.
  - Pulse `grant` for the winner.
  - Latch sign = deg[31], the absolute value, and `out_id`.
  - Clamp: if |deg| > 90, use 90 and set `err`.
  - Go to DIV.
- DIV: restoring division of {abs, 32'd0} by 180.
  - Remainder starts at abs; abs ≤ 90 < 180, so the upper 32 quotient bits are zero.
  - 32 iterations, one per cycle, MSB first. Each iteration: rem = rem << 1; if rem ≥ 180, subtract 180 and the quotient bit is 1, else 0.
  - Remainder register is 9 bits. The quotient is truncated to 32 bits, with no rounding.
  - After iteration 31, go to MULT.
- MULT: product[47:0] = quotient × 16'hC90F, where pi is in 2.14 format.
  - rad = product[47:16].
  - If the latched sign is set, rad = ~product[47:16] + 1.
  - Register `rad`, then go to DONE.
- DONE:
  - `out_valid` = 1; `rad`, `out_id` and `err` are stable.
  - On `out_valid & out_ready`, return to IDLE.
  - While in DONE, no new request is accepted and `grant` stays 0.
- Input 0 and input -0 both yield rad = 0.
- A `req` that drops before its grant is simply not served. No queueing beyond the request lines.

## Timing
- Reset values:
  - State IDLE; `grant` = 0, `busy` = 0, `out_valid` = 0, `out_id` = 0, `rad` = 0, `err` = 0.
  - Divider counter and remainder are 0; the round-robin pointer favours requester 0.
- Let cycle G be the cycle with the `grant` pulse (state IDLE):
  - Cycles G+1 through G+32 are DIV.
  - G+33 is MULT.
  - `out_valid` is first high at G+34.
- Minimum request-to-request spacing is 35 cycles; this holds when `out_ready` is tied high.
- Earliest next grant: the cycle after the handshake cycle, since the block is back in IDLE.
- Result consumed in the same cycle valid rises: the handshake completes at G+34.
- Reset asserted mid-operation immediately aborts the conversion. No `out_valid` is produced for that request; the pointer returns to requester 0.
- `req` is sampled only in IDLE. Both `req` bits high in the same cycle resolve by the pointer, in the same cycle.

## Test plan
- Reset, then `req`=01, `deg0`=90, `out_ready`=1 -> `grant`=01 at G; `out_valid` at G+34; `rad`=32'h64878000, `out_id`=0, `err`=0.
- `deg1`=-90 on requester 1 -> `rad`=32'h9B788000, `out_id`=1. Then `deg1`=45 -> 32'h3243C000. Then `deg1`=0 -> 32'h00000000.
- `deg0`=15 -> `rad`=32'h10C13FFF, confirming quotient truncation. Then `deg0`=200 -> `rad`=32'h64878000 with `err`=1. Then `deg0`=-1000 -> 32'h9B788000 with `err`=1.
- `req`=11 held continuously, `out_ready`=1 -> grants alternate 01,10,01,10 starting with 01 after reset; each result carries the matching `out_id`.
- `out_ready`=0 for 10 cycles after `out_valid` rises -> `out_valid`, `rad`, `out_id` and `busy` stay stable and no `grant` pulses despite `req`=10. The handshake completes when `out_ready` rises, and the next grant follows one cycle later.
- `reset` asserted at G+15 during DIV -> all outputs go to reset values asynchronously. After release, `req`=11 grants requester 0 first and a full 34-cycle conversion follows.
